data_merger: RTL and testbench

//  Return path of the NoC host interface; the inverse of data_splitter.

---
 rtl/data_merger_pkg.sv | 22 ++
 rtl/data_merger_node_fifo.sv | 73 +++++++
 rtl/data_merger.sv | 48 ++++
 tb/tb_data_merger.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/data_merger_pkg.sv
// Shared sizing helpers for the NoC return-path merger.
// Node count, host-bus slice offsets and FIFO counter/pointer widths live here.
package data_merger_pkg;

  function automatic int num_nodes(input int row, input int col);
    return row * col;
  endfunction

  function automatic int node_lsb(input int n, input int data_w);
    return n * data_w;
  endfunction

  // The count needs one extra bit so that "full" is distinguishable from "empty".
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_merger_node_fifo.sv
// One node's ejection FIFO with a registered host-side output and on/off flow control.
// Full + push with a simultaneous pop is accepted; full + push without a pop is dropped.
module merger_node_fifo
  import data_merger_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OFF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              host_off_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              off_o,
  output logic              overflow_o
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] OFF_THR  = CW'(FIFO_DEPTH - OFF_MARGIN);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic              valid_q, off_q, overflow_q;
  logic [DATA_W-1:0] data_q;
  logic              full, empty, push, pop;

  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    pop     = ~empty & ~host_off_i;
    push    = valid_i & (~full | pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      off_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= pop;
      off_q   <= (count_d >= OFF_THR);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        data_q   <= mem_q[rd_ptr_q];
      end
      if (valid_i & full & ~pop) overflow_q <= 1'b1;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign off_o      = off_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/data_merger.sv
// NoC host return path: per-node FIFOs gather router ejections onto one flat host bus.
// This level only unpacks router-side arrays and packs the host-side buses.
module data_merger
  import data_merger_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NODE_PER_ROW = 4,
  parameter int NODE_PER_COL = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int OFF_MARGIN   = 2,
  localparam int N = num_nodes(NODE_PER_ROW, NODE_PER_COL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i_NoC    [0:N-1],
  input  logic [0:DATA_W-1]     data_i_NoC     [0:N-1],
  output logic                  off_sigs_o_NoC [0:N-1],
  output logic [0:N-1]          valid_o_NoC,
  output logic [0:N*DATA_W-1]   data_o_NoC,
  input  logic [0:N-1]          off_sigs_i_NoC,
  output logic [0:N-1]          overflow_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_node
    localparam int LSB = node_lsb(gi, DATA_W);
    logic [DATA_W-1:0] node_data;

    merger_node_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .OFF_MARGIN(OFF_MARGIN)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_i_NoC[gi]),
      .data_i    (data_i_NoC[gi]),
      .host_off_i(off_sigs_i_NoC[gi]),
      .valid_o   (valid_o_NoC[gi]),
      .data_o    (node_data),
      .off_o     (off_sigs_o_NoC[gi]),
      .overflow_o(overflow_o[gi])
    );

    // Node 0 sits on the MSB side of the ascending host bus.
    assign data_o_NoC[LSB +: DATA_W] = node_data;
  end

endmodule

// File: tb/tb_data_merger.sv
// Directed checks of the data_merger return path with hand-computed expectations.
module tb_data_merger;

  localparam int N = 16;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i  [0:N-1];
  logic [0:W-1]     data_i   [0:N-1];
  logic             off_o    [0:N-1];
  logic [0:N-1]     valid_o;
  logic [0:N*W-1]   data_o;
  logic [0:N-1]     off_i;
  logic [0:N-1]     ovf_o;

  int n_checks = 0;
  int n_fail   = 0;

  data_merger dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i_NoC   (valid_i),
    .data_i_NoC    (data_i),
    .off_sigs_o_NoC(off_o),
    .valid_o_NoC   (valid_o),
    .data_o_NoC    (data_o),
    .off_sigs_i_NoC(off_i),
    .overflow_o    (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:N-1] off_vec();
    logic [0:N-1] v;
    for (int n = 0; n < N; n++) v[n] = off_o[n];
    return v;
  endfunction

  task automatic clear_inputs();
    for (int n = 0; n < N; n++) begin
      valid_i[n] = 1'b0;
      data_i[n]  = '0;
    end
    off_i = '0;
  endtask

  task automatic randomize_inputs();
    for (int n = 0; n < N; n++) begin
      valid_i[n] = 1'($urandom_range(0, 1));
      data_i[n]  = 8'($urandom);
    end
    off_i = 16'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 128'(valid_o), 128'h0);
    check_eq({tag, "_data"},  128'(data_o),  128'h0);
    check_eq({tag, "_off"},   128'(off_vec()), 128'h0);
    check_eq({tag, "_ovf"},   128'(ovf_o),   128'h0);
  endtask

  logic [7:0] got_q[$];

  initial begin
    // 1. reset with random inputs
    rst = 1'b1;
    randomize_inputs();
    step();
    check_all_zero("rst_cyc1");
    randomize_inputs();
    step();
    check_all_zero("rst_cyc2");
    rst = 1'b0;
    clear_inputs();
    step();
    check_all_zero("rst_after");

    // 2. single flit on node 5
    valid_i[5] = 1'b1;
    data_i[5]  = 8'hA5;
    step();
    clear_inputs();
    check_eq("single_t1_valid", 128'(valid_o), 128'h0);
    step();
    check_eq("single_valid", 128'(valid_o), 128'h0400);
    check_eq("single_data5", 128'(data_o[40:47]), 128'hA5);
    step();
    check_eq("single_valid_drop", 128'(valid_o), 128'h0);
    check_eq("single_data_hold", 128'(data_o[40:47]), 128'hA5);

    // 3. all nodes in the same cycle
    for (int n = 0; n < N; n++) begin
      valid_i[n] = 1'b1;
      data_i[n]  = 8'hF0;
    end
    step();
    clear_inputs();
    step();
    check_eq("all_valid", 128'(valid_o), 128'hFFFF);
    check_eq("all_data", 128'(data_o), {16{8'hF0}});
    step();
    check_eq("all_valid_drop", 128'(valid_o), 128'h0);

    // 4. host backpressure on node 0
    off_i[0] = 1'b1;
    valid_i[0] = 1'b1;
    data_i[0]  = 8'h11;
    step();
    check_eq("bp_off_after1", 128'(off_vec()), 128'h0);
    data_i[0] = 8'h22;
    step();
    check_eq("bp_off_after2", 128'(off_vec()), 128'h8000);
    data_i[0] = 8'h33;
    step();
    valid_i[0] = 1'b0;
    check_eq("bp_no_valid", 128'(valid_o), 128'h0);
    step();
    check_eq("bp_held_valid", 128'(valid_o), 128'h0);
    check_eq("bp_held_off", 128'(off_vec()), 128'h8000);
    off_i[0] = 1'b0;
    step();
    check_eq("bp_rel1_valid", 128'(valid_o), 128'h8000);
    check_eq("bp_rel1_data", 128'(data_o[0:7]), 128'h11);
    check_eq("bp_rel1_off", 128'(off_vec()), 128'h8000);
    step();
    check_eq("bp_rel2_data", 128'(data_o[0:7]), 128'h22);
    check_eq("bp_rel2_off", 128'(off_vec()), 128'h0);
    step();
    check_eq("bp_rel3_valid", 128'(valid_o), 128'h8000);
    check_eq("bp_rel3_data", 128'(data_o[0:7]), 128'h33);
    step();
    check_eq("bp_drain_valid", 128'(valid_o), 128'h0);

    // 5. overflow on node 3
    off_i[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      valid_i[3] = 1'b1;
      data_i[3]  = 8'(k);
      step();
      if (k == 4) check_eq("ovf_before", 128'(ovf_o), 128'h0);
    end
    valid_i[3] = 1'b0;
    check_eq("ovf_set", 128'(ovf_o), 128'h1000);
    step();
    step();
    check_eq("ovf_sticky", 128'(ovf_o), 128'h1000);
    off_i[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (valid_o[3]) got_q.push_back(data_o[24:31]);
    end
    check_eq("ovf_count", 128'(got_q.size()), 128'd4);
    for (int k = 0; k < got_q.size() && k < 4; k++)
      check_eq($sformatf("ovf_flit%0d", k), 128'(got_q[k]), 128'(k + 1));
    check_eq("ovf_still_set", 128'(ovf_o), 128'h1000);

    // 6. reset mid-operation with node 7 partly full
    off_i[7] = 1'b1;
    valid_i[7] = 1'b1;
    data_i[7]  = 8'h77;
    step();
    data_i[7] = 8'h78;
    step();
    valid_i[7] = 1'b0;
    check_eq("mid_off_pre", 128'(off_vec()), 128'h0100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    off_i = '0;
    check_eq("mid_valid", 128'(valid_o), 128'h0);
    check_eq("mid_off", 128'(off_vec()), 128'h0);
    check_eq("mid_ovf", 128'(ovf_o), 128'h0);
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq($sformatf("mid_no_stale%0d", c), 128'(valid_o), 128'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
